// File: rtl/config_loader_if.sv
// -----------------------------------------------------------------------------
// config_loader_if
// Bundles the serial bitstream input and the tile load-port outputs of
// config_loader.
//   bit_in      : serial bitstream data, MSB of each word first
//   bit_valid   : bit_in is sampled on a rising clk edge only when high
//   config_en   : one-hot write strobe, one bit per tile
//   config_data : configuration word for the strobed tile
//   busy        : high from sync detection until the frame ends or aborts
//   done        : sticky, the frame completed successfully
//   error       : sticky, the frame aborted
// Modports:
//   master : bitstream source / tile array side (drives bit_in, bit_valid)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface config_loader_if #(
    parameter int NUM_TILES = 16
);
    logic                 bit_in;
    logic                 bit_valid;
    logic [NUM_TILES-1:0] config_en;
    logic [31:0]          config_data;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output bit_in,
        output bit_valid,
        input  config_en,
        input  config_data,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output config_en,
        output config_data,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
// Serial configuration loader for the fabric switch-box load ports. Hunts for
// SYNC_WORD in the incoming bitstream, then decodes (header, data) word pairs
// and issues one single-cycle config_en strobe to the addressed tile per pair.
// A header with bit 31 set ends the frame.
//
// Ports:
//   clk    : clock
//   rst    : asynchronous, active-low reset
//   io_cfg : config_loader_if.slave (bit_in, bit_valid, config_en,
//            config_data, busy, done, error)
// Parameters:
//   NUM_TILES : number of tiles driven (one config_en bit each)
//   ADDR_W    : width of the tile index field in the header word
//   SYNC_WORD : frame start pattern
// Build option:
//   CONFIG_LOADER_CRC_EN : when defined, a running XOR of all DATA words is
//   kept and the END header is followed by a checksum word that must match
//   it for done to be set; otherwise error is set.
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int          NUM_TILES = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] SYNC_WORD = 32'hA5C3_0F5A
) (
    input  logic         clk,
    input  logic         rst,
    config_loader_if.slave io_cfg
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    state_t               r_state;
    logic [31:0]          r_sr;
    logic [4:0]           r_bcnt;
    logic [ADDR_W-1:0]    r_idx;
    logic                 r_pend;
    logic [NUM_TILES-1:0] r_config_en;
    logic [31:0]          r_config_data;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
`ifdef CONFIG_LOADER_CRC_EN
    logic [31:0]          r_acc;
`endif

    logic [31:0]          w_sr_next;
    logic                 w_word_done;
    logic                 w_addr_bad;
    logic [NUM_TILES-1:0] w_onehot;

    // Next shift-register value and word-boundary / address decode.
    always_comb begin
        w_sr_next   = {r_sr[30:0], io_cfg.bit_in};
        w_word_done = (r_bcnt == 5'd31);
        w_addr_bad  = ({{(32-ADDR_W){1'b0}}, w_sr_next[ADDR_W-1:0]} >= 32'(NUM_TILES));
    end

    // One-hot decode of the latched tile index.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            w_onehot[i] = (r_idx == ADDR_W'(i));
        end
    end

    // Frame FSM, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_HUNT;
            r_sr          <= 32'h0000_0000;
            r_bcnt        <= 5'd0;
            r_idx         <= '0;
            r_pend        <= 1'b0;
            r_config_en   <= '0;
            r_config_data <= 32'h0000_0000;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            r_acc         <= 32'h0000_0000;
`endif
        end else begin
            // The strobe fires the cycle after the DATA word completes and
            // lasts exactly one cycle; r_pend bridges that one-cycle delay.
            r_config_en <= r_pend ? w_onehot : '0;
            r_pend      <= 1'b0;

            if (io_cfg.bit_valid) begin
                r_sr <= w_sr_next;
                case (r_state)
                    ST_HUNT: begin
                        // Sliding compare on every bit; bcnt is not used here.
                        r_bcnt <= 5'd0;
                        if (w_sr_next == SYNC_WORD) begin
                            r_state <= ST_HEADER;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                            r_acc   <= 32'h0000_0000;
`endif
                        end
                    end

                    ST_HEADER: begin
                        r_bcnt <= r_bcnt + 5'd1;
                        if (w_word_done) begin
                            if (w_sr_next[31]) begin
`ifdef CONFIG_LOADER_CRC_EN
                                r_state <= ST_CHECK;
`else
                                r_state <= ST_HUNT;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
`endif
                            end else if (w_addr_bad) begin
                                r_state <= ST_HUNT;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_idx   <= w_sr_next[ADDR_W-1:0];
                                r_state <= ST_DATA;
                            end
                        end
                    end

                    ST_DATA: begin
                        r_bcnt <= r_bcnt + 5'd1;
                        if (w_word_done) begin
                            r_config_data <= w_sr_next;
                            r_pend        <= 1'b1;
                            r_state       <= ST_HEADER;
`ifdef CONFIG_LOADER_CRC_EN
                            r_acc         <= r_acc ^ w_sr_next;
`endif
                        end
                    end

`ifdef CONFIG_LOADER_CRC_EN
                    ST_CHECK: begin
                        r_bcnt <= r_bcnt + 5'd1;
                        if (w_word_done) begin
                            // Writes already issued in this frame stay in place.
                            if (w_sr_next == r_acc) begin
                                r_done <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                            r_busy  <= 1'b0;
                            r_state <= ST_HUNT;
                        end
                    end
`endif

                    default: begin
                        r_state <= ST_HUNT;
                        r_bcnt  <= 5'd0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_cfg.config_en   = r_config_en;
    assign io_cfg.config_data = r_config_data;
    assign io_cfg.busy        = r_busy;
    assign io_cfg.done        = r_done;
    assign io_cfg.error       = r_error;

endmodule
